res_mem_arbiter: RTL and testbench

// - Shares the single-port 128x128x8 result RAM (res_* bus) between two requesters: port 0 = distance-transform

---
 rtl/res_mem_arbiter_if.sv | 38 +++
 rtl/res_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_res_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/res_mem_arbiter_if.sv
// Requester and result-RAM bus for res_mem_arbiter.
// The arbiter takes the slave modport; requesters and the RAM together form the master side.
interface res_mem_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic          req0;
  logic          req1;
  logic          wr0;
  logic          wr1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          lock0;
  logic          lock1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;
  logic          res_rd;
  logic          res_wr;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_do;
  logic [DW-1:0] res_di;
  logic          busy;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, lock0, lock1, res_di,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, res_rd, res_wr, res_addr, res_do, busy
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, lock0, lock1, res_di,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, res_rd, res_wr, res_addr, res_do, busy
  );
endinterface

// File: rtl/res_mem_arbiter.sv
// Two-port arbiter for the single-port 128x128x8 result RAM (port 0 = DT engine, port 1 = host).
// Define RES_ARB_LOCK_EN to let a port hold the RAM across cycles for read-modify-write bursts.
//   state | meaning
//   ARB   | arbitrate every cycle
//   OWN0  | port 0 owns the RAM, port 1 waits
//   OWN1  | port 1 owns the RAM, port 0 waits
module res_mem_arbiter #(
  parameter int AW        = 14,
  parameter int DW        = 8,
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 15
) (
  input logic              clk,
  input logic              reset,
  res_mem_arbiter_if.slave bus
);

`ifdef RES_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  typedef enum logic [1:0] {ARB, OWN0, OWN1} state_t;

  state_t        state;
  logic          last_gnt;
  logic          rd_owner;
  logic [7:0]    wait_cnt;
  logic          pick0, pick1;
  logic          gnt0, gnt1;
  logic          lock0, lock1;
  logic          acc, acc_wr;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;
  logic          res_rd, res_wr;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_do;
  logic [DW-1:0] rdata;
  logic          rvalid0, rvalid1;

  // With locking compiled out the lock inputs fold to 0 and the FSM never leaves ARB.
  assign lock0 = LOCK_EN & bus.lock0;
  assign lock1 = LOCK_EN & bus.lock1;

  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (PRIO_MODE == 0) begin
      if (bus.req0 && bus.req1) begin
        pick0 = last_gnt;
        pick1 = !last_gnt;
      end else begin
        pick0 = bus.req0;
        pick1 = bus.req1;
      end
    end else begin
      pick1 = bus.req1 && (!bus.req0 || (wait_cnt >= WAIT_LIMIT));
      pick0 = bus.req0 && !pick1;
    end
  end

  // Ownership overrides arbitration, including the starvation-forced grant.
  always_comb begin
    gnt0 = pick0;
    gnt1 = pick1;
    case (state)
      OWN0: begin
        gnt0 = bus.req0;
        gnt1 = 1'b0;
      end
      OWN1: begin
        gnt0 = 1'b0;
        gnt1 = bus.req1;
      end
      default: ;
    endcase
  end

  assign acc      = gnt0 | gnt1;
  assign acc_wr   = gnt1 ? bus.wr1    : bus.wr0;
  assign acc_addr = gnt1 ? bus.addr1  : bus.addr0;
  assign acc_data = gnt1 ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ARB;
      last_gnt <= 1'b1;
      rd_owner <= 1'b0;
      wait_cnt <= 8'd0;
      res_rd   <= 1'b0;
      res_wr   <= 1'b0;
      res_addr <= '0;
      res_do   <= '0;
      rdata    <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      res_rd <= acc & ~acc_wr;
      res_wr <= acc & acc_wr;
      if (acc) begin
        res_addr <= acc_addr;
        res_do   <= acc_data;
        rd_owner <= gnt1;
        last_gnt <= gnt1;
      end

      // res_di answers the address presented during the res_rd cycle.
      rvalid0 <= res_rd & ~rd_owner;
      rvalid1 <= res_rd & rd_owner;
      if (res_rd) begin
        rdata <= res_di_q();
      end

      if (!bus.req1 || gnt1) begin
        wait_cnt <= 8'd0;
      end else if (wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      case (state)
        ARB: begin
          if (gnt0 && lock0) begin
            state <= OWN0;
          end else if (gnt1 && lock1) begin
            state <= OWN1;
          end
        end
        OWN0: begin
          if (!lock0 || !bus.req0) begin
            state <= ARB;
          end
        end
        OWN1: begin
          if (!lock1 || !bus.req1) begin
            state <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  function automatic logic [DW-1:0] res_di_q();
    return bus.res_di;
  endfunction

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.rvalid0  = rvalid0;
  assign bus.rvalid1  = rvalid1;
  assign bus.rdata    = rdata;
  assign bus.res_rd   = res_rd;
  assign bus.res_wr   = res_wr;
  assign bus.res_addr = res_addr;
  assign bus.res_do   = res_do;
  assign bus.busy     = res_rd;

endmodule

// File: tb/tb_res_mem_arbiter.sv
// Directed self-checking bench for res_mem_arbiter: a round-robin and a fixed-priority instance,
// each backed by a behavioural result RAM with asynchronous read and clocked write.
module tb_res_mem_arbiter;
  localparam int AW = 14;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  res_mem_arbiter_if #(.AW(AW), .DW(DW)) if_rr ();
  res_mem_arbiter_if #(.AW(AW), .DW(DW)) if_fx ();

  res_mem_arbiter #(.AW(AW), .DW(DW), .PRIO_MODE(0), .MAX_WAIT(15)) u_rr (
    .clk(clk), .reset(reset), .bus(if_rr));
  res_mem_arbiter #(.AW(AW), .DW(DW), .PRIO_MODE(1), .MAX_WAIT(3)) u_fx (
    .clk(clk), .reset(reset), .bus(if_fx));

  // Unwritten locations read back as pat(addr); stored values are kept xor-ed with it.
  function automatic logic [7:0] pat(input logic [13:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  bit [7:0] mem_rr [16384];
  bit [7:0] mem_fx [16384];

  always @(posedge clk) begin
    if (if_rr.res_wr) mem_rr[if_rr.res_addr] <= if_rr.res_do ^ pat(if_rr.res_addr);
    if (if_fx.res_wr) mem_fx[if_fx.res_addr] <= if_fx.res_do ^ pat(if_fx.res_addr);
  end
  assign if_rr.res_di = mem_rr[if_rr.res_addr] ^ pat(if_rr.res_addr);
  assign if_fx.res_di = mem_fx[if_fx.res_addr] ^ pat(if_fx.res_addr);

  task automatic drive_idle();
    if_rr.req0 = 1'b0; if_rr.req1 = 1'b0; if_rr.wr0 = 1'b0; if_rr.wr1 = 1'b0;
    if_rr.lock0 = 1'b0; if_rr.lock1 = 1'b0; if_rr.addr0 = '0; if_rr.addr1 = '0;
    if_rr.wdata0 = '0; if_rr.wdata1 = '0;
    if_fx.req0 = 1'b0; if_fx.req1 = 1'b0; if_fx.wr0 = 1'b0; if_fx.wr1 = 1'b0;
    if_fx.lock0 = 1'b0; if_fx.lock1 = 1'b0; if_fx.addr0 = '0; if_fx.addr1 = '0;
    if_fx.wdata0 = '0; if_fx.wdata1 = '0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive_idle();
    end
  endtask

  task automatic test_reset();
    logic [36:0] v;
    reset = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    v = {if_rr.gnt0, if_rr.gnt1, if_rr.rvalid0, if_rr.rvalid1, if_rr.res_rd, if_rr.res_wr,
         if_rr.busy, if_rr.res_addr, if_rr.res_do, if_rr.rdata};
    checks++;
    if (v !== 37'd0) begin
      failures++; $display("FAIL reset_rr_in_reset got %h expected 0", v);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    v = {if_rr.gnt0, if_rr.gnt1, if_rr.rvalid0, if_rr.rvalid1, if_rr.res_rd, if_rr.res_wr,
         if_rr.busy, if_rr.res_addr, if_rr.res_do, if_rr.rdata};
    checks++;
    if (v !== 37'd0) begin
      failures++; $display("FAIL reset_rr_after_release got %h expected 0", v);
    end
    v = {if_fx.gnt0, if_fx.gnt1, if_fx.rvalid0, if_fx.rvalid1, if_fx.res_rd, if_fx.res_wr,
         if_fx.busy, if_fx.res_addr, if_fx.res_do, if_fx.rdata};
    checks++;
    if (v !== 37'd0) begin
      failures++; $display("FAIL reset_fx_after_release got %h expected 0", v);
    end
  endtask

  // Both ports read continuously; each port moves to its next address once granted.
  task automatic test_round_robin();
    logic       eg0, eg1, ev0, ev1;
    logic [7:0] ed;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if_rr.req0  = (c < 6);
      if_rr.req1  = (c < 6);
      if_rr.wr0   = 1'b0;
      if_rr.wr1   = 1'b0;
      if_rr.addr0 = 14'h0100 + 14'((c + 1) / 2);
      if_rr.addr1 = 14'h0240 + 14'(c / 2);
      @(negedge clk);
      eg0 = (c < 6) && (c % 2 == 0);
      eg1 = (c < 6) && (c % 2 == 1);
      checks++;
      if ({if_rr.gnt0, if_rr.gnt1} !== {eg0, eg1}) begin
        failures++;
        $display("FAIL rr_gnt c=%0d got %b%b expected %b%b", c, if_rr.gnt0, if_rr.gnt1, eg0, eg1);
      end
      if (c >= 2) begin
        ev0 = ((c - 2) % 2 == 0);
        ev1 = !ev0;
        ed  = ev0 ? pat(14'h0100 + 14'((c - 2) / 2)) : pat(14'h0240 + 14'((c - 2) / 2));
        checks++;
        if ({if_rr.rvalid0, if_rr.rvalid1, if_rr.rdata} !== {ev0, ev1, ed}) begin
          failures++;
          $display("FAIL rr_rvalid c=%0d got %b%b/%h expected %b%b/%h", c,
                   if_rr.rvalid0, if_rr.rvalid1, if_rr.rdata, ev0, ev1, ed);
        end
      end
    end
    idle_cycles(3);
  endtask

  task automatic test_lock();
    logic        eg0 [6];
    logic        eg1 [6];
    logic [13:0] a0;
`ifdef RES_ARB_LOCK_EN
    eg0 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    eg1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    eg0 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    eg1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
    a0 = 14'h3F7F;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if_rr.req0  = (c < 4);
      if_rr.lock0 = (c < 4);
      if_rr.wr0   = 1'b0;
      if_rr.addr0 = a0;
      if_rr.req1  = 1'b1;
      if_rr.wr1   = 1'b0;
      if_rr.addr1 = 14'h0010;
      @(negedge clk);
      checks++;
      if ({if_rr.gnt0, if_rr.gnt1} !== {eg0[c], eg1[c]}) begin
        failures++;
        $display("FAIL lock_gnt c=%0d got %b%b expected %b%b", c, if_rr.gnt0, if_rr.gnt1, eg0[c], eg1[c]);
      end
      if (if_rr.gnt0) a0 = a0 + 14'd1;
    end
    idle_cycles(3);
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    if_rr.req0 = 1'b1; if_rr.wr0 = 1'b1; if_rr.addr0 = 14'h0081; if_rr.wdata0 = 8'h05;
    @(negedge clk);
    checks++;
    if (if_rr.gnt0 !== 1'b1) begin
      failures++; $display("FAIL wr_gnt got %b expected 1", if_rr.gnt0);
    end
    @(posedge clk); #1;
    if_rr.wr0 = 1'b0; if_rr.wdata0 = 8'h00;
    @(negedge clk);
    checks++;
    if ({if_rr.res_wr, if_rr.res_rd, if_rr.res_addr, if_rr.res_do, if_rr.gnt0} !== {1'b1, 1'b0, 14'h0081, 8'h05, 1'b1}) begin
      failures++;
      $display("FAIL wr_strobe got wr=%b rd=%b addr=%h do=%h gnt0=%b expected 1 0 0081 05 1",
               if_rr.res_wr, if_rr.res_rd, if_rr.res_addr, if_rr.res_do, if_rr.gnt0);
    end
    @(posedge clk); #1;
    if_rr.req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rr.res_rd, if_rr.res_wr, if_rr.res_addr, if_rr.busy, if_rr.rvalid0} !== {1'b1, 1'b0, 14'h0081, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL rd_strobe got rd=%b wr=%b addr=%h busy=%b rvalid0=%b expected 1 0 0081 1 0",
               if_rr.res_rd, if_rr.res_wr, if_rr.res_addr, if_rr.busy, if_rr.rvalid0);
    end
    @(negedge clk);
    checks++;
    if ({if_rr.rvalid0, if_rr.rvalid1, if_rr.rdata, if_rr.busy} !== {1'b1, 1'b0, 8'h05, 1'b0}) begin
      failures++;
      $display("FAIL rd_return got rvalid=%b%b rdata=%h busy=%b expected 10 05 0",
               if_rr.rvalid0, if_rr.rvalid1, if_rr.rdata, if_rr.busy);
    end
    @(negedge clk);
    checks++;
    if (if_rr.rvalid0 !== 1'b0) begin
      failures++; $display("FAIL rd_pulse_width got %b expected 0", if_rr.rvalid0);
    end
    idle_cycles(2);
  endtask

  task automatic test_fixed_priority();
    logic eg0, eg1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if_fx.req0  = (c < 7);
      if_fx.req1  = (c != 6);
      if_fx.wr0   = 1'b0;
      if_fx.wr1   = 1'b0;
      if_fx.addr0 = 14'h0300;
      if_fx.addr1 = 14'h1234;
      @(negedge clk);
      eg1 = (c == 3) || (c == 7);
      eg0 = (c < 7) && (c != 3);
      checks++;
      if ({if_fx.gnt0, if_fx.gnt1} !== {eg0, eg1}) begin
        failures++;
        $display("FAIL fx_gnt c=%0d got %b%b expected %b%b", c, if_fx.gnt0, if_fx.gnt1, eg0, eg1);
      end
      if (c == 5) begin
        checks++;
        if ({if_fx.rvalid0, if_fx.rvalid1, if_fx.rdata} !== {1'b0, 1'b1, 8'h6E}) begin
          failures++;
          $display("FAIL fx_rvalid1 got %b%b/%h expected 01/6e", if_fx.rvalid0, if_fx.rvalid1, if_fx.rdata);
        end
      end
    end
    idle_cycles(3);
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    if_rr.req0 = 1'b1; if_rr.wr0 = 1'b0; if_rr.addr0 = 14'h0055;
    @(negedge clk);
    checks++;
    if (if_rr.gnt0 !== 1'b1) begin
      failures++; $display("FAIL mid_gnt got %b expected 1", if_rr.gnt0);
    end
    @(posedge clk); #1;
    if_rr.req0 = 1'b0;
    checks++;
    if (if_rr.res_rd !== 1'b1) begin
      failures++; $display("FAIL mid_inflight got %b expected 1", if_rr.res_rd);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({if_rr.res_rd, if_rr.busy} !== 2'b00) begin
      failures++; $display("FAIL mid_async_clear got rd=%b busy=%b expected 0 0", if_rr.res_rd, if_rr.busy);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({if_rr.rvalid0, if_rr.rvalid1} !== 2'b00) begin
        failures++; $display("FAIL mid_no_rvalid got %b%b expected 00", if_rr.rvalid0, if_rr.rvalid1);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    if_rr.req0 = 1'b1; if_rr.wr0 = 1'b0; if_rr.addr0 = 14'h0055;
    @(negedge clk);
    checks++;
    if (if_rr.gnt0 !== 1'b1) begin
      failures++; $display("FAIL post_reset_gnt got %b expected 1", if_rr.gnt0);
    end
    @(posedge clk); #1;
    if_rr.req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({if_rr.rvalid0, if_rr.rdata} !== {1'b1, 8'h0F}) begin
      failures++;
      $display("FAIL post_reset_read got %b/%h expected 1/0f", if_rr.rvalid0, if_rr.rdata);
    end
    idle_cycles(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    test_reset();
    test_round_robin();
    test_lock();
    test_write_read();
    test_fixed_priority();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
